// File: rtl/lenet_frame_ctrl_if.sv
// Stream and pipeline signals of the lenet frame sequencer.
// The slave modport is the sequencer's view; master is the upstream/pipeline side.
interface lenet_frame_ctrl_if #(
  parameter int ACT_W = 400,
  parameter int OUT_W = 256
);
  logic             in_valid;
  logic [ACT_W-1:0] in_data;
  logic             in_ready;
  logic             net_valid;
  logic [ACT_W-1:0] net_act;
  logic             net_flush;
  logic             net_ready;
  logic [OUT_W-1:0] net_out;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, net_ready, net_out,
    input  in_ready, net_valid, net_act, net_flush, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, net_ready, net_out,
    output in_ready, net_valid, net_act, net_flush, out_valid, out_data, out_last
  );
endinterface

// File: rtl/lenet_frame_ctrl.sv
// Frame sequencer for the lenet pipeline: feeds one frame of input vectors,
// collects the expected outputs, flushes the line buffers and reports done/error.
module lenet_frame_ctrl #(
  parameter int ACT_W     = 400,
  parameter int OUT_W     = 256,
  parameter int N_IN      = 1024,
  parameter int N_OUT     = 25,
  parameter int FLUSH_CYC = 4,
  parameter int TIMEOUT   = 4096,
  parameter int CW        = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [2:0]          error,
  lenet_frame_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, FLUSH, DONE} state_t;

  localparam logic [CW-1:0] IN_LAST  = CW'(N_IN - 1);
  localparam logic [CW-1:0] OUT_FULL = CW'(N_OUT);
  localparam logic [CW-1:0] OUT_LAST = CW'(N_OUT - 1);
  localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FL_LAST  = CW'(FLUSH_CYC - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    in_cnt, out_cnt, wd_cnt, fl_cnt;
  logic             hs, frame_act, start_acc, capture, overflow;
  logic             set_timeout, set_abort;
  logic             net_valid_q, net_flush_q, out_valid_q, out_last_q;
  logic [ACT_W-1:0] net_act_q;
  logic [OUT_W-1:0] out_data_q;

  assign bus.in_ready  = (state == FEED);
  assign bus.net_valid = net_valid_q;
  assign bus.net_act   = net_act_q;
  assign bus.net_flush = net_flush_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  assign hs        = bus.in_valid & (state == FEED);
  assign frame_act = (state == FEED) || (state == DRAIN);
  assign start_acc = (state == IDLE) && start;
  assign capture   = frame_act && bus.net_ready && (out_cnt < OUT_FULL);
  assign overflow  = frame_act && bus.net_ready && (out_cnt == OUT_FULL);

  // Next-state selection; abort takes priority over the normal FEED/DRAIN exits.
  always_comb begin
    state_nxt   = state;
    set_timeout = 1'b0;
    set_abort   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FEED;
      FEED: begin
        if (abort) begin
          state_nxt = FLUSH;
          set_abort = 1'b1;
        end else if (hs && (in_cnt == IN_LAST)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = FLUSH;
          set_abort = 1'b1;
        end else if (out_cnt == OUT_FULL) begin
          state_nxt = FLUSH;
        end else if ((wd_cnt == WD_LAST) && !bus.net_ready) begin
          state_nxt   = FLUSH;
          set_timeout = 1'b1;
        end
      end
      FLUSH: if (fl_cnt == FL_LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame counters: inputs accepted, outputs forwarded, drain watchdog, flush length.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      wd_cnt  <= '0;
      fl_cnt  <= '0;
    end else begin
      if (start_acc) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (hs)      in_cnt  <= in_cnt + CW'(1);
        if (capture) out_cnt <= out_cnt + CW'(1);
      end
      if ((state != DRAIN) || bus.net_ready) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + CW'(1);
      if (state != FLUSH) fl_cnt <= '0;
      else                fl_cnt <= fl_cnt + CW'(1);
    end
  end

  // Sticky per-frame error flags, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          error <= 3'b000;
    else if (start_acc) error <= 3'b000;
    else                error <= error | {set_abort, overflow, set_timeout};
  end

  // Registered pipeline input and forwarded pipeline output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      net_valid_q <= 1'b0;
      net_act_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      net_valid_q <= hs;
      if (hs) net_act_q <= bus.in_data;
      out_valid_q <= capture;
      out_last_q  <= capture && (out_cnt == OUT_LAST);
      if (capture) out_data_q <= bus.net_out;
    end
  end

  // Status outputs registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      net_flush_q <= 1'b0;
    end else begin
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      net_flush_q <= (state_nxt == FLUSH);
    end
  end

endmodule

// File: tb/tb_lenet_frame_ctrl.sv
// Directed bench for lenet_frame_ctrl with a queue scoreboard for the
// pipeline-input and forwarded-output streams.
module tb_lenet_frame_ctrl;

  localparam int ACT_W     = 400;
  localparam int OUT_W     = 256;
  localparam int N_IN      = 4;
  localparam int N_OUT     = 2;
  localparam int FLUSH_CYC = 2;
  localparam int TIMEOUT   = 8;
  localparam int CW        = 16;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done;
  logic [2:0] error;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [ACT_W-1:0] act_q[$];
  logic [OUT_W:0]   out_q[$];
  logic [OUT_W:0]   mon_e;

  lenet_frame_ctrl_if #(.ACT_W(ACT_W), .OUT_W(OUT_W)) bus ();

  lenet_frame_ctrl #(
    .ACT_W(ACT_W), .OUT_W(OUT_W), .N_IN(N_IN), .N_OUT(N_OUT),
    .FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .start(start),
    .abort(abort),
    .busy (busy),
    .done (done),
    .error(error),
    .bus  (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every pipeline-input and forwarded-output beat must match the queue head.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.net_valid === 1'b1) begin
        if (act_q.size() == 0) checkOutput("net_valid_spurious", bus.net_valid, 1'b0);
        else                   checkOutput("net_act", bus.net_act, act_q.pop_front());
      end
      if (bus.out_valid === 1'b1) begin
        if (out_q.size() == 0) begin
          checkOutput("out_valid_spurious", bus.out_valid, 1'b0);
        end else begin
          mon_e = out_q.pop_front();
          checkOutput("out_data", bus.out_data, mon_e[OUT_W-1:0]);
          checkOutput("out_last", bus.out_last, mon_e[OUT_W]);
        end
      end else if (bus.out_last !== 1'b0) begin
        checkOutput("out_last_without_valid", bus.out_last, 1'b0);
      end
    end
  end

  function automatic logic [ACT_W-1:0] randAct();
    logic [415:0] t;
    for (int w = 0; w < 13; w++) t[w*32 +: 32] = $urandom();
    return t[ACT_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] randOut();
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom();
    return t[OUT_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, record what the DUT should produce from it, and advance a clock.
  task automatic applyStimulus(input logic st, input logic ab, input logic iv,
                               input logic [ACT_W-1:0] id, input logic nr,
                               input logic [OUT_W-1:0] no, input logic exp_acc,
                               input logic exp_cap, input logic exp_last);
    start         = st;
    abort         = ab;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.net_ready = nr;
    bus.net_out   = no;
    if (exp_acc) act_q.push_back(id);
    if (exp_cap) out_q.push_back({exp_last, no});
    tick();
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Run idle cycles until done, counting cycles before and during flush; bounded wait.
  task automatic runToDone(input int exp_pre, input int exp_flush, input logic [2:0] exp_err);
    int pre  = 0;
    int fl   = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idleStep();
      if (done === 1'b1)             seen = 1'b1;
      else if (bus.net_flush === 1'b1) fl++;
      else if (fl == 0)              pre++;
    end
    checkOutput("done_seen", seen, 1'b1);
    checkOutput("pre_flush_cycles", pre, exp_pre);
    checkOutput("flush_cycles", fl, exp_flush);
    checkOutput("error_at_done", error, exp_err);
    idleStep();
    checkOutput("done_single_pulse", done, 1'b0);
    checkOutput("busy_after_done", busy, 1'b0);
    checkOutput("error_hold", error, exp_err);
    checkOutput("act_q_drained", act_q.size(), 0);
    checkOutput("out_q_drained", out_q.size(), 0);
  endtask

  task automatic runNominal();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("nom_busy", busy, 1'b1);
    checkOutput("nom_in_ready", bus.in_ready, 1'b1);
    checkOutput("nom_error_clear", error, 3'b000);
    for (int i = 0; i < N_IN; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, randAct(), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("nom_net_valid", bus.net_valid, 1'b1);
      checkOutput("nom_in_ready_feed", bus.in_ready, i < N_IN - 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, randOut(), 1'b0, 1'b1, 1'b0);
    checkOutput("nom_net_valid_drain", bus.net_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, randOut(), 1'b0, 1'b1, 1'b1);
    checkOutput("nom_flush_before", bus.net_flush, 1'b0);
    runToDone(0, FLUSH_CYC, 3'b000);
  endtask

  // Directed scenarios in sequence.
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.net_ready = 1'b0;
    bus.net_out   = '0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 3'b000);
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_net_valid", bus.net_valid, 1'b0);
    checkOutput("rst_net_act", bus.net_act, '0);
    checkOutput("rst_net_flush", bus.net_flush, 1'b0);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_data", bus.out_data, '0);
    checkOutput("rst_out_last", bus.out_last, 1'b0);
    rstn = 1'b1;
    tick();

    // Nominal frame
    $display("[TB] nominal frame");
    runNominal();

    // Gapped upstream
    $display("[TB] gapped upstream");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * N_IN - 1; i++) begin
      logic iv;
      iv = (i % 2) == 0;
      applyStimulus(1'b0, 1'b0, iv, randAct(), 1'b0, '0, iv, 1'b0, 1'b0);
      checkOutput("gap_net_valid", bus.net_valid, iv);
      checkOutput("gap_in_ready", bus.in_ready, i < 2 * N_IN - 2);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, randOut(), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, randOut(), 1'b0, 1'b1, 1'b1);
    runToDone(0, FLUSH_CYC, 3'b000);

    // Timeout: one output during FEED, then silence through DRAIN
    $display("[TB] drain timeout");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N_IN; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, randAct(), i == 1, randOut(), 1'b1, i == 1, 1'b0);
    end
    checkOutput("to_in_ready_drain", bus.in_ready, 1'b0);
    runToDone(TIMEOUT - 1, FLUSH_CYC, 3'b001);

    // Overflow: three outputs while feeding, only two forwarded
    $display("[TB] output overflow");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N_IN; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, randAct(), i < 3, randOut(), 1'b1, i < 2, i == 1);
    end
    checkOutput("ovf_error_mid", error, 3'b010);
    runToDone(0, FLUSH_CYC, 3'b010);

    // Abort after two inputs, with a start issued during FLUSH
    $display("[TB] abort");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, randAct(), 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_in_ready", bus.in_ready, 1'b0);
    checkOutput("abort_flush1", bus.net_flush, 1'b1);
    checkOutput("abort_net_valid", bus.net_valid, 1'b0);
    checkOutput("abort_error", error, 3'b100);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_flush2", bus.net_flush, 1'b1);
    checkOutput("abort_start_ignored_error", error, 3'b100);
    runToDone(0, 0, 3'b100);
    checkOutput("abort_stays_idle", bus.in_ready, 1'b0);

    // Reset in the middle of FEED, then a clean nominal frame
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, randAct(), 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    rstn = 1'b0;
    #1;
    checkOutput("mrst_busy", busy, 1'b0);
    checkOutput("mrst_in_ready", bus.in_ready, 1'b0);
    checkOutput("mrst_net_valid", bus.net_valid, 1'b0);
    checkOutput("mrst_net_act", bus.net_act, '0);
    checkOutput("mrst_net_flush", bus.net_flush, 1'b0);
    checkOutput("mrst_out_valid", bus.out_valid, 1'b0);
    checkOutput("mrst_error", error, 3'b000);
    checkOutput("mrst_done", done, 1'b0);
    act_q.delete();
    out_q.delete();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    runNominal();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
